// File: rtl/spi_frame_parser.sv
// Byte-stream frame parser: A5 CMD ADDR LEN payload [CHK] -> one register write per payload byte.
// Define FRAME_CHKSUM_EN to require and verify the trailing CHK byte (modulo-256 sum of CMD..payload).
module spi_frame_parser #(
   parameter int P_MAX_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_vld,
   input  logic       ss_n,
   output logic       wr_en,
   output logic [7:0] wr_cmd,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_done,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       ovf
);
   localparam int         IW      = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN = 8'(P_MAX_LEN);
   localparam logic [7:0] HDR     = 8'hA5;

   // state | meaning: IDLE hunt A5 | CMD/ADDR/LEN header fields | PAYLOAD fill buffer | CHK verify | EMIT writes
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_LEN, S_PAYLOAD,
`ifdef FRAME_CHKSUM_EN
      S_CHK,
`endif
      S_EMIT
   } state_t;

   state_t        state_q;
   logic [7:0]    buf_q [P_MAX_LEN];
   logic [7:0]    addr_q, len_q, idx_q;
   logic          wr_en_q, frame_done_q, frame_err_q, ovf_q;
   logic [7:0]    wr_cmd_q, wr_addr_q, wr_data_q;
   logic [1:0]    err_code_q;
   logic          buf_we;
   logic [IW-1:0] idx_nx;

   assign buf_we = (state_q == S_PAYLOAD) && din_vld && !ss_n;
   assign idx_nx = IW'(idx_q + 8'd1);

   always_ff @(posedge clk) begin
      if (buf_we) buf_q[idx_q[IW-1:0]] <= din;
   end

`ifdef FRAME_CHKSUM_EN
   logic [7:0] sum_q;
   always_ff @(posedge clk) begin
      if (rst) sum_q <= 8'd0;
      else if (din_vld && !ss_n) begin
         case (state_q)
            S_CMD:                    sum_q <= din;
            S_ADDR, S_LEN, S_PAYLOAD: sum_q <= sum_q + din;
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_en_q      <= 1'b0;
         wr_cmd_q     <= 8'd0;
         wr_addr_q    <= 8'd0;
         wr_data_q    <= 8'd0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= 2'b00;
         ovf_q        <= 1'b0;
         addr_q       <= 8'd0;
         len_q        <= 8'd0;
         idx_q        <= 8'd0;
      end else begin
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (din_vld) begin
                  if (din == HDR) state_q <= S_CMD;
                  else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= 2'b01;
                  end
               end
            end
            S_EMIT: begin
               if (din_vld) ovf_q <= 1'b1;
               if (idx_q == len_q - 8'd1) begin
                  wr_en_q      <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  idx_q     <= idx_q + 8'd1;
                  wr_addr_q <= addr_q + idx_q + 8'd1;
                  wr_data_q <= buf_q[idx_nx];
               end
            end
            default: begin
               // slave-select release beats a same-cycle byte
               if (ss_n) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'b00;
                  state_q     <= S_IDLE;
               end else if (din_vld) begin
                  case (state_q)
                     S_CMD: begin
                        wr_cmd_q <= din;
                        state_q  <= S_ADDR;
                     end
                     S_ADDR: begin
                        addr_q  <= din;
                        state_q <= S_LEN;
                     end
                     S_LEN: begin
                        if (din == 8'd0 || din > MAX_LEN) begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 2'b10;
                           state_q     <= S_IDLE;
                        end else begin
                           len_q   <= din;
                           idx_q   <= 8'd0;
                           state_q <= S_PAYLOAD;
                        end
                     end
                     S_PAYLOAD: begin
                        if (idx_q == len_q - 8'd1) begin
`ifdef FRAME_CHKSUM_EN
                           state_q <= S_CHK;
`else
                           // a 1-byte frame's only byte is still on din, not yet in the buffer
                           state_q   <= S_EMIT;
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= addr_q;
                           wr_data_q <= (idx_q == 8'd0) ? din : buf_q[0];
                           idx_q     <= 8'd0;
`endif
                        end else begin
                           idx_q <= idx_q + 8'd1;
                        end
                     end
`ifdef FRAME_CHKSUM_EN
                     S_CHK: begin
                        if (din == sum_q) begin
                           state_q   <= S_EMIT;
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= addr_q;
                           wr_data_q <= buf_q[0];
                           idx_q     <= 8'd0;
                        end else begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 2'b11;
                           state_q     <= S_IDLE;
                        end
                     end
`endif
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_cmd     = wr_cmd_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_spi_frame_parser.sv
// Bench for spi_frame_parser: vector table, hand-built corner sequences and random frames
// judged by a frame-level reference model.
module tb_spi_frame_parser;
   localparam int MAXL = 16;
`ifdef FRAME_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, din_vld, ss_n;
   logic [7:0] din;
   logic       wr_en, frame_done, frame_err, ovf;
   logic [7:0] wr_cmd, wr_addr, wr_data;
   logic [1:0] err_code;

   spi_frame_parser #(.P_MAX_LEN(MAXL)) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .ss_n(ss_n),
      .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] b [24];
      int         n;
      bit         err;
      logic [1:0] code;
      int         nwr;
   } vec_t;

   wr_t        got_wr[$], exp_wr[$];
   logic [1:0] got_err[$], exp_err[$];
   int         got_done = 0;
   int         exp_done;
   int         checks = 0;
   int         errors = 0;
   vec_t       tv[$];
   logic [7:0] tmp[$];
   logic [7:0] fb[$];
   int         wb, db, eb;

   // passive monitor: every output event observed mid-cycle
   always @(negedge clk) begin
      if (wr_en) got_wr.push_back({wr_cmd, wr_addr, wr_data});
      if (frame_done) got_done++;
      if (frame_err) got_err.push_back(err_code);
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] b, input logic v, input logic s);
      @(negedge clk);
      din     = b;
      din_vld = v;
      ss_n    = s;
   endtask

   task automatic send_frame(input int gapmax, input int tail);
      for (int i = 0; i < fb.size(); i++) begin
         put(fb[i], 1'b1, 1'b0);
         if (gapmax > 0) repeat ($urandom_range(0, gapmax)) put(8'h00, 1'b0, 1'b0);
      end
      repeat (tail) put(8'h00, 1'b0, 1'b0);
   endtask

   // reference: judge a whole frame from the format rules
   task automatic model_frame();
      int         len;
      logic [7:0] s;
      exp_wr   = {};
      exp_err  = {};
      exp_done = 0;
      if (fb[0] != 8'hA5) begin
         exp_err.push_back(2'b01);
         return;
      end
      len = int'(fb[3]);
      if (len == 0 || len > MAXL) begin
         exp_err.push_back(2'b10);
         return;
      end
      if (CHK_EN) begin
         s = 8'h00;
         for (int i = 1; i < 4 + len; i++) s = s + fb[i];
         if (s != fb[4 + len]) begin
            exp_err.push_back(2'b11);
            return;
         end
      end
      for (int k = 0; k < len; k++) exp_wr.push_back({fb[1], 8'(int'(fb[2]) + k), fb[4 + k]});
      exp_done = 1;
   endtask

   task automatic mark();
      wb = got_wr.size();
      db = got_done;
      eb = got_err.size();
   endtask

   task automatic check_sb(input string nm);
      int n;
      n = got_wr.size() - wb;
      chk({nm, " nwr"}, n, exp_wr.size());
      for (int k = 0; k < n && k < exp_wr.size(); k++)
         chk($sformatf("%s wr%0d", nm, k), int'(got_wr[wb + k]), int'(exp_wr[k]));
      chk({nm, " done"}, got_done - db, exp_done);
      n = got_err.size() - eb;
      chk({nm, " nerr"}, n, exp_err.size());
      for (int k = 0; k < n && k < exp_err.size(); k++)
         chk($sformatf("%s code%0d", nm, k), int'(got_err[eb + k]), int'(exp_err[k]));
   endtask

   task automatic add_vec(input bit with_chk, input bit err, input logic [1:0] code, input int nwr);
      vec_t       v;
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 24; i++) v.b[i] = 8'h00;
      for (int i = 0; i < tmp.size(); i++) begin
         v.b[i] = tmp[i];
         if (i > 0) s = s + tmp[i];
      end
      v.n = tmp.size();
      if (with_chk && CHK_EN) begin
         v.b[v.n] = s;
         v.n++;
      end
      v.err  = err;
      v.code = code;
      v.nwr  = nwr;
      tv.push_back(v);
   endtask

   task automatic build_good(input int len);
      fb = {8'hA5, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'(len)};
      for (int k = 0; k < len; k++) fb.push_back(8'($urandom_range(0, 255)));
      if (CHK_EN) begin
         logic [7:0] s = 8'h00;
         for (int i = 1; i < fb.size(); i++) s = s + fb[i];
         fb.push_back(s);
      end
   endtask

   initial begin
      rst = 1'b1; din = 8'h00; din_vld = 1'b0; ss_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset outputs", int'({wr_en, frame_done, frame_err, ovf, err_code, wr_cmd, wr_addr, wr_data}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      tmp = '{8'hA5, 8'h10, 8'h20, 8'h03, 8'h11, 8'h22, 8'h33}; add_vec(1, 0, 2'b00, 3);
      tmp = '{8'h5A};                                            add_vec(0, 1, 2'b01, 0);
      tmp = '{8'hA5, 8'h01, 8'hFE, 8'h02, 8'hAA, 8'hBB};         add_vec(1, 0, 2'b00, 2);
      tmp = '{8'hA5, 8'h10, 8'h20, 8'h11};                       add_vec(0, 1, 2'b10, 0);
      tmp = '{8'hA5, 8'h10, 8'h20, 8'h00};                       add_vec(0, 1, 2'b10, 0);
      tmp = '{8'hA5, 8'h07, 8'h30, 8'h10};
      for (int k = 0; k < MAXL; k++) tmp.push_back(8'(k * 13 + 1));
      add_vec(1, 0, 2'b00, MAXL);
      tmp = '{8'hA5, 8'h22, 8'hFF, 8'h01, 8'h5C};                add_vec(1, 0, 2'b00, 1);

      for (int i = 0; i < tv.size(); i++) begin
         fb = {};
         for (int j = 0; j < tv[i].n; j++) fb.push_back(tv[i].b[j]);
         model_frame();
         mark();
         send_frame(2, 24);
         chk($sformatf("vec%0d err", i), got_err.size() - eb, tv[i].err ? 1 : 0);
         if (tv[i].err && got_err.size() > eb)
            chk($sformatf("vec%0d code", i), int'(got_err[eb]), int'(tv[i].code));
         chk($sformatf("vec%0d writes", i), got_wr.size() - wb, tv[i].nwr);
         check_sb($sformatf("vec%0d", i));
      end

`ifdef FRAME_CHKSUM_EN
      fb = {8'hA5, 8'h10, 8'h20, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
      mark();
      send_frame(0, 20);
      exp_wr = {}; exp_err = {2'b11}; exp_done = 0;
      check_sb("bad chk");
`endif

      // ss_n release after ADDR, then ss_n high in IDLE must stay silent
      mark();
      put(8'hA5, 1'b1, 1'b0); put(8'h10, 1'b1, 1'b0); put(8'h20, 1'b1, 1'b0);
      repeat (5) put(8'h00, 1'b0, 1'b1);
      put(8'h00, 1'b0, 1'b0);
      exp_wr = {}; exp_err = {2'b00}; exp_done = 0;
      check_sb("abort addr");

      // abort and byte strobe in the same cycle: byte discarded
      mark();
      put(8'hA5, 1'b1, 1'b0); put(8'h10, 1'b1, 1'b0); put(8'h20, 1'b1, 1'b0);
      put(8'h01, 1'b1, 1'b0); put(8'h22, 1'b1, 1'b1);
      repeat (4) put(8'h00, 1'b0, 1'b1);
      put(8'h00, 1'b0, 1'b0);
      exp_wr = {}; exp_err = {2'b00}; exp_done = 0;
      check_sb("abort same cycle");

      // ss_n ignored during EMIT
      build_good(5);
      model_frame();
      mark();
      send_frame(0, 0);
      repeat (10) put(8'h00, 1'b0, 1'b1);
      put(8'h00, 1'b0, 1'b0);
      check_sb("ss_n in emit");
      chk("ovf clear", int'(ovf), 0);

      // bytes during EMIT are dropped and flag ovf
      build_good(4);
      model_frame();
      mark();
      send_frame(0, 0);
      put(8'hA5, 1'b1, 1'b0);
      put(8'h10, 1'b1, 1'b0);
      repeat (10) put(8'h00, 1'b0, 1'b0);
      check_sb("ovf emit");
      chk("ovf set", int'(ovf), 1);
      build_good(2);
      model_frame();
      mark();
      send_frame(1, 12);
      check_sb("after ovf");
      chk("ovf sticky", int'(ovf), 1);

      // reset mid-EMIT: two writes out, then silence and no frame_done
      build_good(5);
      mark();
      send_frame(0, 0);
      put(8'h00, 1'b0, 1'b0);
      put(8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst emit wr_en", int'(wr_en), 0);
      chk("rst emit ovf", int'(ovf), 0);
      rst = 1'b0;
      repeat (10) put(8'h00, 1'b0, 1'b0);
      chk("rst emit writes", got_wr.size() - wb, 2);
      chk("rst emit done", got_done - db, 0);
      chk("rst emit err", got_err.size() - eb, 0);

      for (int r = 0; r < 40; r++) begin
         int kind;
         kind = $urandom_range(0, CHK_EN ? 3 : 2);
         build_good($urandom_range(1, MAXL));
         if (kind == 1) begin
            logic [7:0] h;
            h = 8'($urandom_range(0, 255));
            if (h == 8'hA5) h = 8'h3C;
            fb = {h};
         end else if (kind == 2) begin
            fb = {8'hA5, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))};
         end else if (kind == 3) begin
            fb[fb.size() - 1] = fb[fb.size() - 1] ^ 8'($urandom_range(1, 255));
         end
         model_frame();
         mark();
         send_frame(3, MAXL + 10);
         check_sb($sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
